clk_divider_multi: RTL and testbench

Multi-channel programmable clock divider, successor to the single-channel even-only divider. Each of CHANNELS independent channels divides `clk` by its own integer N (2 to 2^WIDTH-1, even or odd) with 50% duty cycle, using half-cycle resolution for odd N. Each channel also produces a one-cycle `tick` strobe aligned to its period start. Sits in the clock/timing utility layer and feeds downstream blocks that need slow strobes or derived clocks.

---
 rtl/clk_divider_multi_if.sv | 14 +
 rtl/clk_divider_multi.sv | 117 +++++++++++
 tb/tb_clk_divider_multi.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_multi_if.sv
// Control/status bundle for the multi-channel clock divider: per-channel
// enables and packed divide factors in, divided clocks and tick strobes out.
interface clk_divider_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*WIDTH-1:0] N;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       tick;

  modport master (output enable, output N, input out, input tick);
  modport slave  (input enable, input N, output out, output tick);
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider. Each channel divides clk by its
// own factor N (2..2^WIDTH-1) with 50% duty; odd factors get the extra half
// cycle of high time from a falling-edge copy of the rising-edge phase flop.
// Each channel also emits a one-cycle tick at the start of every period.
module clk_divider_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic               clk,
  input  logic               reset,
  clk_divider_multi_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_tick;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           r_state, w_state_nxt;
      logic [WIDTH-1:0] r_ncur, w_ncur_nxt;
      logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
      logic             r_p, w_p_nxt;
      logic             r_tick, w_tick_nxt;
      logic             r_q;
      logic [WIDTH-1:0] w_n_in;
      logic [WIDTH-1:0] w_half;
      logic [WIDTH-1:0] w_cnt_inc;
      logic             w_n_ok;
      logic             w_last;

      assign w_n_in    = bus.N[c*WIDTH +: WIDTH];
      assign w_n_ok    = (w_n_in >= TWO);
      assign w_half    = r_ncur >> 1;
      assign w_cnt_inc = r_cnt + ONE;
      assign w_last    = (r_cnt == (r_ncur - ONE));

      // Next-state: start, step through the period, reload at the boundary, or stop.
      always_comb begin
        w_state_nxt = r_state;
        w_ncur_nxt  = r_ncur;
        w_cnt_nxt   = r_cnt;
        w_p_nxt     = 1'b0;
        w_tick_nxt  = 1'b0;
        if (r_state == IDLE) begin
          if (bus.enable[c] && w_n_ok) begin
            w_state_nxt = RUN;
            w_ncur_nxt  = w_n_in;
            w_cnt_nxt   = ZERO;
            w_p_nxt     = 1'b1;
            w_tick_nxt  = 1'b1;
          end
        end else begin
          if (!bus.enable[c]) begin
            // Disable abandons the current period, even on a boundary edge.
            w_state_nxt = IDLE;
            w_cnt_nxt   = ZERO;
          end else if (w_last) begin
            if (w_n_ok) begin
              // Seamless reload: the next period starts on this very edge.
              w_ncur_nxt = w_n_in;
              w_cnt_nxt  = ZERO;
              w_p_nxt    = 1'b1;
              w_tick_nxt = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = ZERO;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_p_nxt   = (w_cnt_inc < w_half);
          end
        end
      end

      // Rising-edge channel state register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= IDLE;
          r_ncur  <= ZERO;
          r_cnt   <= ZERO;
          r_p     <= 1'b0;
          r_tick  <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_ncur  <= w_ncur_nxt;
          r_cnt   <= w_cnt_nxt;
          r_p     <= w_p_nxt;
          r_tick  <= w_tick_nxt;
        end
      end

      // Falling-edge copy of the phase flop; stretches odd-N high time by half a cycle.
      always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
          r_q <= 1'b0;
        end else begin
          r_q <= r_p;
        end
      end

      // p and q never toggle on the same edge, so their OR cannot glitch.
      assign w_out[c]  = r_ncur[0] ? (r_p | r_q) : r_p;
      assign w_tick[c] = r_tick;
    end
  endgenerate

  assign bus.out  = w_out;
  assign bus.tick = w_tick;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi: a phase-counting reference model
// predicts out/tick for each half clock cycle; a monitor compares them.
module tb_clk_divider_multi;

  localparam int W = 8;
  localparam int C = 2;

  typedef struct {
    logic [C-1:0] o;
    logic [C-1:0] t;
  } exp_t;

  logic clk;
  logic reset;

  clk_divider_multi_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  clk_divider_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: whether the channel is running, how many cycles into the
  // current period it is, the period length, and the level out had during the
  // second half of the previous cycle.
  int m_act  [C];
  int m_k    [C];
  int m_n    [C];
  bit m_prev [C];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_bits(input string name, input logic [C-1:0] act, input logic [C-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_act[c]  = 0;
      m_k[c]    = 0;
      m_n[c]    = 0;
      m_prev[c] = 1'b0;
    end
  endtask

  // Advance the model by one rising edge and queue the two half-cycle predictions.
  task automatic model_step(input logic [C-1:0] en, input logic [C*W-1:0] nv);
    exp_t e1, e2;
    e1.o = '0; e1.t = '0; e2.o = '0; e2.t = '0;
    for (int c = 0; c < C; c++) begin
      int  nin;
      bit  high;
      nin = int'(nv[c*W +: W]);
      if (m_act[c] == 0) begin
        if (en[c] && nin >= 2) begin
          m_act[c] = 1; m_n[c] = nin; m_k[c] = 0;
        end
      end else if (!en[c]) begin
        m_act[c] = 0; m_k[c] = 0;
      end else if (m_k[c] == m_n[c] - 1) begin
        if (nin >= 2) begin
          m_n[c] = nin; m_k[c] = 0;
        end else begin
          m_act[c] = 0; m_k[c] = 0;
        end
      end else begin
        m_k[c] = m_k[c] + 1;
      end
      high    = (m_act[c] != 0) && (m_k[c] < m_n[c] / 2);
      e1.o[c] = high | ((m_n[c] % 2 == 1) && m_prev[c]);
      e1.t[c] = (m_act[c] != 0) && (m_k[c] == 0);
      e2.o[c] = high;
      e2.t[c] = e1.t[c];
      m_prev[c] = high;
    end
    q_exp.push_back(e1);
    q_exp.push_back(e2);
  endtask

  task automatic drive(input logic [C-1:0] en, input logic [C*W-1:0] nv);
    @(negedge clk);
    #2;
    reset      = 1'b0;
    bus.enable = en;
    bus.N      = nv;
    model_step(en, nv);
  endtask

  task automatic run(input logic [C-1:0] en, input logic [W-1:0] n0, input logic [W-1:0] n1, input int cycles);
    for (int i = 0; i < cycles; i++) drive(en, {n1, n0});
  endtask

  task automatic pulse_reset();
    exp_t z;
    z.o = '0; z.t = '0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    q_exp.push_back(z);
    q_exp.push_back(z);
    #1;
    check_bits("async_reset_out", bus.out, '0);
    check_bits("async_reset_tick", bus.tick, '0);
  endtask

  task automatic pop_check(input string phase);
    exp_t e;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check_bits({"out_", phase}, bus.out, e.o);
      check_bits({"tick_", phase}, bus.tick, e.t);
    end
  endtask

  // Monitor: compare DUT outputs shortly after each rising and each falling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pop_check("rise");
      @(negedge clk);
      #1;
      pop_check("fall");
    end
  end

  initial begin
    logic [C-1:0] en;
    logic [W-1:0] nsel [C];
    reset      = 1'b1;
    bus.enable = '0;
    bus.N      = '0;
    model_reset();
    #3;
    check_bits("reset_out", bus.out, '0);
    check_bits("reset_tick", bus.tick, '0);

    // Basic even and odd factors on channel 0.
    run(2'b01, 8'd2, 8'd0, 8);
    run(2'b01, 8'd4, 8'd0, 12);
    run(2'b00, 8'd4, 8'd0, 1);
    run(2'b01, 8'd3, 8'd0, 12);
    run(2'b00, 8'd3, 8'd0, 2);
    // Two channels concurrently with different periods.
    run(2'b11, 8'd5, 8'd6, 30);
    run(2'b00, 8'd0, 8'd0, 2);
    // Factor change mid-period takes effect only at the boundary.
    run(2'b01, 8'd4, 8'd0, 2);
    run(2'b01, 8'd6, 8'd0, 20);
    // Illegal factor stops the channel at the boundary and keeps it idle.
    run(2'b01, 8'd0, 8'd0, 8);
    run(2'b00, 8'd0, 8'd0, 1);
    run(2'b01, 8'd0, 8'd1, 10);
    run(2'b11, 8'd1, 8'd0, 4);
    // Disable mid-high, then restart from the period start.
    run(2'b01, 8'd6, 8'd0, 2);
    run(2'b00, 8'd6, 8'd0, 3);
    run(2'b01, 8'd6, 8'd0, 8);
    // Odd factor disabled while high keeps out up until the next falling edge.
    run(2'b00, 8'd5, 8'd0, 1);
    run(2'b01, 8'd5, 8'd0, 2);
    run(2'b00, 8'd5, 8'd0, 2);
    // Reset mid-period on both channels, then restart.
    run(2'b11, 8'd6, 8'd7, 4);
    pulse_reset();
    run(2'b11, 8'd6, 8'd7, 16);

    // Randomized traffic.
    en      = 2'b11;
    nsel[0] = 8'd3;
    nsel[1] = 8'd8;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < C; c++) begin
        int r;
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 15) == 0) begin
          r = int'($urandom_range(0, 9));
          if (r == 0)      nsel[c] = W'($urandom_range(0, 1));
          else if (r < 8)  nsel[c] = W'($urandom_range(2, 9));
          else             nsel[c] = W'($urandom_range(2, 255));
        end
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else drive(en, {nsel[1], nsel[0]});
    end

    repeat (2) @(negedge clk);
    #3;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
